// File: rtl/cond_pkg.sv
// Shared definitions for the condition-gating stage: condition encodings,
// NZCV bit positions and FlagW bit meanings.
package cond_pkg;

    // Condition field encodings (Instr[31:28])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions within {N,Z,C,V}
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // FlagW bit meanings
    localparam int unsigned FW_NZ = 1;  // write N and Z
    localparam int unsigned FW_CV = 0;  // write C and V

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: (Cond, NZCV) -> condition pass.
// NV_IS_AL selects whether encoding 1111 always or never executes.
module cond_eval
    import cond_pkg::*;
#(
    parameter bit NV_IS_AL = 1'b1
) (
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    // Decode the condition field against the supplied flags
    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = !w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = !w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = !w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = !w_v;
            COND_HI: o_cond_ex = w_c && !w_z;
            COND_LS: o_cond_ex = !w_c || w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = !w_z && (w_n == w_v);
            COND_LE: o_cond_ex = w_z || (w_n != w_v);
            COND_AL: o_cond_ex = 1'b1;
            COND_NV: o_cond_ex = NV_IS_AL;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_gate_unit.sv
// Condition-gating stage: holds NZCV, registers the condition-pass bit and
// qualifies the decoder's raw write strobes with it.
// Optional feature: COND_STICKY_Q_EN adds a sticky overflow (Q) register.
module cond_gate_unit
    import cond_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter bit         NV_IS_AL    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       RegWHi,
    input  logic       QClr,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       RegWriteHi,
    output logic [3:0] Flags,
    output logic       CondExR,
    output logic       QFlag
);

    logic [3:0] r_flags;
    logic       r_cond_ex;
    logic       w_cond_ex;

    // Condition is judged on the registered flags, never on this cycle's ALU result
    cond_eval #(
        .NV_IS_AL(NV_IS_AL)
    ) u_cond_eval (
        .i_cond   (Cond),
        .i_flags  (r_flags),
        .o_cond_ex(w_cond_ex)
    );

    // Flag and condition-pass registers; flag writes gated by the registered pass bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags   <= RESET_FLAGS;
            r_cond_ex <= 1'b0;
        end else begin
            r_cond_ex <= w_cond_ex;
            if (FlagW[FW_NZ] && r_cond_ex) begin
                r_flags[FLAG_N] <= ALUFlags[FLAG_N];
                r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[FW_CV] && r_cond_ex) begin
                r_flags[FLAG_C] <= ALUFlags[FLAG_C];
                r_flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

`ifdef COND_STICKY_Q_EN
    logic r_q;

    // Sticky overflow: a qualified V write sets it, QClr clears it, set wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= 1'b0;
        end else if (FlagW[FW_CV] && r_cond_ex && ALUFlags[FLAG_V]) begin
            r_q <= 1'b1;
        end else if (QClr) begin
            r_q <= 1'b0;
        end
    end

    assign QFlag = r_q;
`else
    logic w_qclr_unused;

    assign w_qclr_unused = QClr;
    assign QFlag         = 1'b0;
`endif

    // Zero-latency strobe qualification; NextPC fetch is never suppressed
    always_comb begin
        PCWrite    = (PCS && r_cond_ex) || NextPC;
        RegWrite   = RegW && r_cond_ex;
        MemWrite   = MemW && r_cond_ex;
        RegWriteHi = RegWHi && r_cond_ex;
    end

    assign Flags   = r_flags;
    assign CondExR = r_cond_ex;

endmodule

// File: tb/tb_cond_gate_unit.sv
// Self-checking bench for cond_gate_unit with a behavioural reference model.
// Honours COND_STICKY_Q_EN in the same way as the design.
module tb_cond_gate_unit;

    localparam logic [3:0] RST_FLAGS = 4'b0000;
    localparam bit         NV_AL     = 1'b1;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, NextPC, RegW, MemW, RegWHi, QClr;
    logic       PCWrite, RegWrite, MemWrite, RegWriteHi;
    logic [3:0] Flags;
    logic       CondExR;
    logic       QFlag;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    logic [3:0] m_flags;
    logic       m_cx;
    logic       m_q;

    cond_gate_unit #(
        .RESET_FLAGS(RST_FLAGS),
        .NV_IS_AL   (NV_AL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Cond      (Cond),
        .ALUFlags  (ALUFlags),
        .FlagW     (FlagW),
        .PCS       (PCS),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .RegWHi    (RegWHi),
        .QClr      (QClr),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .RegWriteHi(RegWriteHi),
        .Flags     (Flags),
        .CondExR   (CondExR),
        .QFlag     (QFlag)
    );

    always #5 clk = ~clk;

    // Architectural condition rule: even codes test a base predicate, odd codes its inverse
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return NV_AL;
        return c[0] ? ~base : base;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Flags"},   Flags,   m_flags);
        chk({tag, ".CondExR"}, {3'b0, CondExR}, {3'b0, m_cx});
        chk({tag, ".QFlag"},   {3'b0, QFlag},   {3'b0, m_q});
        chk({tag, ".PCWrite"}, {3'b0, PCWrite}, {3'b0, (PCS & m_cx) | NextPC});
        chk({tag, ".RegWrite"}, {3'b0, RegWrite}, {3'b0, RegW & m_cx});
        chk({tag, ".MemWrite"}, {3'b0, MemWrite}, {3'b0, MemW & m_cx});
        chk({tag, ".RegWriteHi"}, {3'b0, RegWriteHi}, {3'b0, RegWHi & m_cx});
    endtask

    task automatic model_reset();
        m_flags = RST_FLAGS;
        m_cx    = 1'b0;
        m_q     = 1'b0;
    endtask

    // Advance one clock: model computes next state from pre-edge inputs and state
    task automatic tick(input string tag, input bit full);
        logic [3:0] nf;
        logic       ncx, nq;
        nf  = m_flags;
        ncx = ref_cond(Cond, m_flags);
        nq  = m_q;
        if (m_cx && FlagW[1]) nf[3:2] = ALUFlags[3:2];
        if (m_cx && FlagW[0]) nf[1:0] = ALUFlags[1:0];
`ifdef COND_STICKY_Q_EN
        if (m_cx && FlagW[0] && ALUFlags[0]) nq = 1'b1;
        else if (QClr) nq = 1'b0;
`endif
        @(posedge clk);
        if (!reset) model_reset();
        else begin
            m_flags = nf;
            m_cx    = ncx;
            m_q     = nq;
        end
        #1;
        if (full) check_all(tag);
    endtask

    task automatic idle_inputs();
        ALUFlags = '0; FlagW = '0; PCS = 0; NextPC = 0;
        RegW = 0; MemW = 0; RegWHi = 0; QClr = 0;
    endtask

    // Load an arbitrary NZCV via an AL instruction with a full flag write
    task automatic load_flags(input logic [3:0] f);
        idle_inputs();
        Cond = 4'hE;
        tick("ld_al", 1'b0);
        FlagW = 2'b11; ALUFlags = f;
        tick("ld_wr", 1'b0);
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        Cond  = 4'h0;
        idle_inputs();
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;
        tick("post_rst", 1'b1);

        // Flag set (ADDS) and EQ/NE check
        Cond = 4'hE;
        tick("adds_dec", 1'b1);
        FlagW = 2'b11; ALUFlags = 4'b0100;
        tick("adds_wr", 1'b1);
        chk("adds_flags", Flags, 4'b0100);
        idle_inputs();
        Cond = 4'h0;
        tick("eq_eval", 1'b1);
        RegW = 1'b1;
        #1;
        chk("eq_regwrite", {3'b0, RegWrite}, 4'd1);
        Cond = 4'h1;
        tick("ne_eval", 1'b1);
        chk("ne_regwrite", {3'b0, RegWrite}, 4'd0);

        // Partial flag write
        load_flags(4'b1111);
        Cond = 4'hE;
        tick("part_dec", 1'b1);
        FlagW = 2'b10; ALUFlags = 4'b0000;
        tick("part_wr", 1'b1);
        chk("part_flags", Flags, 4'b0011);

        // Failed branch, NextPC still fetches
        load_flags(4'b0000);
        Cond = 4'h0;
        tick("br_eval", 1'b1);
        PCS = 1'b1; NextPC = 1'b0;
        #1;
        chk("br_fail_pcw", {3'b0, PCWrite}, 4'd0);
        NextPC = 1'b1;
        #1;
        chk("br_nextpc_pcw", {3'b0, PCWrite}, 4'd1);
        // Suppressed flag write on failed condition
        FlagW = 2'b11; ALUFlags = 4'b1111;
        tick("br_nowr", 1'b1);
        chk("fail_noflag", Flags, 4'b0000);
        idle_inputs();

        // Exhaustive cond x NZCV sweep
        for (int f = 0; f < 16; f++) begin
            load_flags(f[3:0]);
            for (int c = 0; c < 16; c++) begin
                Cond = c[3:0];
                tick("sweep", 1'b0);
                chk($sformatf("sweep_f%0h_c%0h", f, c), {3'b0, CondExR},
                    {3'b0, ref_cond(c[3:0], f[3:0])});
            end
        end

        // Sticky Q sequence (model expects 0 throughout when the feature is absent)
        load_flags(4'b0000);
        Cond = 4'hE;
        tick("q_dec", 1'b1);
        FlagW = 2'b01; ALUFlags = 4'b0001;
        tick("q_set", 1'b1);
        ALUFlags = 4'b0000;
        tick("q_hold", 1'b1);
        QClr = 1'b1; ALUFlags = 4'b0001;
        tick("q_setwins", 1'b1);
        FlagW = 2'b00; ALUFlags = 4'b0000;
        tick("q_clr", 1'b1);
        QClr = 1'b0;
        tick("q_after", 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            Cond     = 4'($urandom);
            ALUFlags = 4'($urandom);
            FlagW    = 2'($urandom);
            PCS      = 1'($urandom);
            NextPC   = 1'($urandom);
            RegW     = 1'($urandom);
            MemW     = 1'($urandom);
            RegWHi   = 1'($urandom);
            QClr     = ($urandom_range(0, 7) == 0);
            tick("rand", 1'b1);
        end

        // Asynchronous reset mid-instruction
        load_flags(4'b1010);
        Cond = 4'hE; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
        tick("pre_arst", 1'b1);
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        tick("in_rst", 1'b1);
        reset = 1'b1;
        tick("rst_rel", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
